// File: rtl/vga_swap_pkg.sv
// Shared constants for the VGA buffer swap controller: pixel buffer control
// slave register map, the status bit polled for swap completion, and the
// sequencer state type.
package vga_swap_pkg;

   // Pixel buffer DMA control slave word addresses
   localparam logic [1:0] REG_BUFFER     = 2'd0;
   localparam logic [1:0] REG_BACKBUFFER = 2'd1;
   localparam logic [1:0] REG_STATUS     = 2'd3;

   // STATUS bit that stays 1 while a swap is waiting for vertical sync
   localparam int STATUS_SWAP_BIT = 0;

   localparam logic [3:0] BE_ALL = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WR_BACK   = 3'd1,
      ST_WR_SWAP   = 3'd2,
      ST_POLL_RD   = 3'd3,
      ST_POLL_WAIT = 3'd4,
      ST_GAP       = 3'd5,
      ST_DONE      = 3'd6
   } swap_state_e;

endpackage

// File: rtl/vga_buffer_swap_ctrl.sv
// VGA front/back buffer swap sequencer for the pixel buffer DMA control slave.
// Takes one renderer request at a time, writes the new back-buffer address,
// triggers the swap and polls STATUS until the swap lands at vertical sync.
//
// Optional feature: define VGA_SWAP_TIMEOUT_EN to bound the polling phase by
// TIMEOUT_CYCLES; an expired swap finishes with done_error=1. Without the
// macro polling is unbounded and done_error is always 0.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | ready for a request, captures req_back_addr on accept
// ST_WR_BACK   | write captured address to BACKBUFFER
// ST_WR_SWAP   | write BUFFER to trigger the swap
// ST_POLL_RD   | issue STATUS read
// ST_POLL_WAIT | read data returns, test swap-pending bit
// ST_GAP       | idle POLL_GAP cycles before the next STATUS read
// ST_DONE      | one-cycle completion pulse, bump frame_count on success
module vga_buffer_swap_ctrl
   import vga_swap_pkg::*;
#(
   parameter int POLL_GAP       = 4,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int FCNT_W         = 16
) (
   input  logic              sys_clk_clk,
   input  logic              sys_reset_reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_back_addr,
   output logic              done_valid,
   output logic              done_error,
   output logic              busy,
   output logic [FCNT_W-1:0] frame_count,
   output logic [1:0]        pb_address,
   output logic [3:0]        pb_byteenable,
   output logic              pb_read,
   output logic              pb_write,
   output logic [31:0]       pb_writedata,
   input  logic [31:0]       pb_readdata
);

   // GAP counts down from POLL_GAP-1 to 0, giving POLL_GAP cycles in GAP
   localparam logic [7:0] GAP_LOAD = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

   swap_state_e        state_q, state_d;
   logic [31:0]        addr_q, addr_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [7:0]         gap_q, gap_d;
   logic               err_q, err_d;
   logic               expire;
   logic               swap_pending;
   logic [30:0]        unused_rdata;

   assign swap_pending = pb_readdata[STATUS_SWAP_BIT];
   assign unused_rdata = pb_readdata[31:1];

`ifdef VGA_SWAP_TIMEOUT_EN
   localparam logic [31:0] TO_LOAD = 32'(TIMEOUT_CYCLES);

   logic [31:0] to_q, to_d;

   // Timeout counter: loaded on the way into WR_SWAP, runs down while polling
   always_comb begin
      to_d = to_q;
      if (state_q == ST_WR_BACK) begin
         to_d = TO_LOAD;
      end else if ((state_q == ST_POLL_RD || state_q == ST_POLL_WAIT ||
                    state_q == ST_GAP) && to_q != 32'd0) begin
         to_d = to_q - 32'd1;
      end
   end

   // Timeout counter register
   always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
      if (sys_reset_reset) begin
         to_q <= 32'd0;
      end else begin
         to_q <= to_d;
      end
   end

   // Counter reaches zero in this cycle
   assign expire = (to_q <= 32'd1);
`else
   logic [31:0] unused_timeout;

   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign expire         = 1'b0;
`endif

   // Next-state, request capture, gap counting and frame counting
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      fcnt_d  = fcnt_q;
      gap_d   = gap_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_back_addr;
               err_d   = 1'b0;
               state_d = ST_WR_BACK;
            end
         end
         ST_WR_BACK: begin
            state_d = ST_WR_SWAP;
         end
         ST_WR_SWAP: begin
            state_d = ST_POLL_RD;
         end
         ST_POLL_RD: begin
            state_d = ST_POLL_WAIT;
         end
         ST_POLL_WAIT: begin
            // a completed swap beats a timeout landing in the same cycle
            if (!swap_pending) begin
               state_d = ST_DONE;
            end else if (expire) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (POLL_GAP == 0) begin
               state_d = ST_POLL_RD;
            end else begin
               gap_d   = GAP_LOAD;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (expire) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (gap_q == 8'd0) begin
               state_d = ST_POLL_RD;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         ST_DONE: begin
            if (!err_q) begin
               fcnt_d = fcnt_q + 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers
   always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
      if (sys_reset_reset) begin
         state_q <= ST_IDLE;
         addr_q  <= 32'd0;
         fcnt_q  <= '0;
         gap_q   <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         fcnt_q  <= fcnt_d;
         gap_q   <= gap_d;
         err_q   <= err_d;
      end
   end

   // Moore decode of handshake, bus strobes and completion pulse
   always_comb begin
      req_ready     = 1'b0;
      busy          = 1'b1;
      done_valid    = 1'b0;
      done_error    = 1'b0;
      pb_address    = 2'd0;
      pb_byteenable = 4'h0;
      pb_read       = 1'b0;
      pb_write      = 1'b0;
      pb_writedata  = 32'd0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_WR_BACK: begin
            pb_write      = 1'b1;
            pb_address    = REG_BACKBUFFER;
            pb_byteenable = BE_ALL;
            pb_writedata  = addr_q;
         end
         ST_WR_SWAP: begin
            pb_write      = 1'b1;
            pb_address    = REG_BUFFER;
            pb_byteenable = BE_ALL;
         end
         ST_POLL_RD: begin
            pb_read       = 1'b1;
            pb_address    = REG_STATUS;
            pb_byteenable = BE_ALL;
         end
         ST_DONE: begin
            done_valid = 1'b1;
            done_error = err_q;
         end
         default: begin
         end
      endcase
   end

   assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_buffer_swap_ctrl.sv
module tb_vga_buffer_swap_ctrl;

   localparam int POLL_GAP       = 4;
   localparam int TIMEOUT_CYCLES = 50;
   localparam int FCNT_W         = 4;
   localparam int PERIOD         = POLL_GAP + 2;   // cycles from one STATUS read to the next
   localparam int FC_MOD         = 1 << FCNT_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [31:0]       req_back_addr = 32'd0;
   logic              done_valid;
   logic              done_error;
   logic              busy;
   logic [FCNT_W-1:0] frame_count;
   logic [1:0]        pb_address;
   logic [3:0]        pb_byteenable;
   logic              pb_read;
   logic              pb_write;
   logic [31:0]       pb_writedata;
   logic [31:0]       pb_readdata = 32'd0;

   int total = 0;
   int bad   = 0;
   int exp_fc = 0;        // reference count of successful swaps, modulo 2**FCNT_W
   int busy_polls = 0;    // STATUS reads still to return pending; negative = never completes
   int cyc = 0;
   bit rd_seen = 1'b0;

   vga_buffer_swap_ctrl #(
      .POLL_GAP(POLL_GAP),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .FCNT_W(FCNT_W)
   ) dut (
      .sys_clk_clk(clk),
      .sys_reset_reset(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_back_addr(req_back_addr),
      .done_valid(done_valid),
      .done_error(done_error),
      .busy(busy),
      .frame_count(frame_count),
      .pb_address(pb_address),
      .pb_byteenable(pb_byteenable),
      .pb_read(pb_read),
      .pb_write(pb_write),
      .pb_writedata(pb_writedata),
      .pb_readdata(pb_readdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Slave model: STATUS read data appears one cycle after the read strobe;
   // upper bits are random, and bit0 is random junk when no read is answered.
   always @(negedge clk) rd_seen = pb_read;

   always @(posedge clk) begin
      logic [31:0] r;
      #1;
      r = $urandom;
      if (rd_seen) begin
         r[0] = (busy_polls != 0);
         if (busy_polls > 0) busy_polls--;
      end
      pb_readdata = r;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish before it");
      $fatal(1);
   end

   task automatic run_swap(input logic [31:0] addr, input int k, input string nm);
      int t_acc, rel, done_rel;
      bit got, done_err, proto_ok, timing_ok;
      int rd_rel[$];
      int wr_rel[$];
      logic [1:0] wr_a[$];
      logic [31:0] wr_d[$];
      busy_polls = k;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_back_addr = addr;
      got = 1'b0;
      t_acc = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1;
            t_acc = cyc;
         end
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL %s accept: req_ready stayed 0, required 1", nm);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_back_addr = $urandom;
      done_rel = -1;
      done_err = 1'b0;
      proto_ok = 1'b1;
      for (int i = 0; i < 300 && done_rel < 0; i++) begin
         @(negedge clk);
         rel = cyc - t_acc;
         if (!busy || req_ready || (pb_read && pb_write) ||
             pb_byteenable !== ((pb_read || pb_write) ? 4'hF : 4'h0) ||
             (pb_read && pb_address !== 2'd3))
            proto_ok = 1'b0;
         if (pb_write) begin
            wr_rel.push_back(rel);
            wr_a.push_back(pb_address);
            wr_d.push_back(pb_writedata);
         end
         if (pb_read) rd_rel.push_back(rel);
         if (done_valid) begin
            done_rel = rel;
            done_err = done_error;
         end
      end
      total++;
      if (!proto_ok) begin
         bad++;
         $display("FAIL %s bus_protocol: busy/ready/strobe/byteenable rule broken while busy, required clean", nm);
      end
      total++;
      if (wr_rel.size() != 2 ||
          wr_rel[0] != 1 || wr_a[0] !== 2'd1 || wr_d[0] !== addr ||
          wr_rel[1] != 2 || wr_a[1] !== 2'd0 || wr_d[1] !== 32'd0) begin
         bad++;
         if (wr_rel.size() >= 1)
            $display("FAIL %s writes: got %0d writes, first at +%0d addr %0d data %h, required 2 writes: +1 addr 1 data %h, +2 addr 0 data 0",
                     nm, wr_rel.size(), wr_rel[0], wr_a[0], wr_d[0], addr);
         else
            $display("FAIL %s writes: got 0 writes, required 2", nm);
      end
      total++;
      if (rd_rel.size() != k + 1) begin
         bad++;
         $display("FAIL %s read_count: got %0d, required %0d", nm, rd_rel.size(), k + 1);
      end
      timing_ok = 1'b1;
      foreach (rd_rel[i]) if (rd_rel[i] != 3 + i * PERIOD) timing_ok = 1'b0;
      total++;
      if (!timing_ok) begin
         bad++;
         $display("FAIL %s read_timing: first read at +%0d, required reads at +3 every %0d cycles",
                  nm, (rd_rel.size() > 0) ? rd_rel[0] : -1, PERIOD);
      end
      total++;
      if (done_rel != 5 + k * PERIOD) begin
         bad++;
         $display("FAIL %s done_latency: got +%0d, required +%0d", nm, done_rel, 5 + k * PERIOD);
      end
      total++;
      if (done_err !== 1'b0) begin
         bad++;
         $display("FAIL %s done_error: got %0b, required 0", nm, done_err);
      end
      if (done_rel >= 0) exp_fc = (exp_fc + 1) % FC_MOD;
      @(negedge clk);
      total++;
      if (frame_count !== FCNT_W'(exp_fc) || busy !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s after_done: frame_count=%0d busy=%0b ready=%0b, required %0d 0 1",
                  nm, frame_count, busy, req_ready, exp_fc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 || done_error !== 1'b0 ||
          pb_read !== 1'b0 || pb_write !== 1'b0 || pb_byteenable !== 4'h0 ||
          pb_address !== 2'd0 || pb_writedata !== 32'd0 || frame_count !== '0) begin
         bad++;
         $display("FAIL reset_hold: ready=%0b busy=%0b rd=%0b wr=%0b be=%h fc=%0d, required ready=1 others 0",
                  req_ready, busy, pb_read, pb_write, pb_byteenable, frame_count);
      end
      rst = 1'b0;
      exp_fc = 0;
      repeat (2) @(negedge clk);
      total++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 || frame_count !== '0) begin
         bad++;
         $display("FAIL reset_release: ready=%0b busy=%0b done=%0b fc=%0d, required 1 0 0 0",
                  req_ready, busy, done_valid, frame_count);
      end
   endtask

   task automatic test_single_swap();
      run_swap(32'h0800_0000, 0, "single");
   endtask

   task automatic test_poll_busy();
      run_swap($urandom, 3, "busy3");
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run_swap($urandom, int'($urandom_range(0, 3)), "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      bit chg, drop, rdy_bad;
      int acc[$];
      int done_c[$];
      int wb_c[$];
      logic [31:0] wb_d[$];
      a = $urandom;
      b = $urandom;
      busy_polls = 0;
      chg = 1'b0;
      drop = 1'b0;
      rdy_bad = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_back_addr = a;
      for (int i = 0; i < 80 && done_c.size() < 2; i++) begin
         @(negedge clk);
         if (drop) req_valid = 1'b0;
         if (chg) begin
            req_back_addr = b;
            chg = 1'b0;
         end
         if (busy && req_ready) rdy_bad = 1'b1;
         if (pb_write && pb_address == 2'd1) begin
            wb_c.push_back(cyc);
            wb_d.push_back(pb_writedata);
         end
         if (done_valid) done_c.push_back(cyc);
         if (req_valid && req_ready) begin
            acc.push_back(cyc);
            if (acc.size() == 1) chg = 1'b1;
            if (acc.size() == 2) drop = 1'b1;
         end
      end
      req_valid = 1'b0;
      total++;
      if (rdy_bad) begin
         bad++;
         $display("FAIL b2b ready_while_busy: req_ready=1 seen with busy=1, required 0");
      end
      total++;
      if (acc.size() != 2 || done_c.size() < 1 || acc[1] != done_c[0] + 1) begin
         bad++;
         $display("FAIL b2b second_accept: accepts=%0d, required 2 with second at first done+1", acc.size());
      end
      total++;
      if (wb_c.size() != 2 || wb_d[0] !== a || wb_d[1] !== b ||
          acc.size() != 2 || wb_c[1] != acc[1] + 1) begin
         bad++;
         $display("FAIL b2b back_addr: writes=%0d, required 2 carrying %h then %h", wb_c.size(), a, b);
      end
      total++;
      if (done_c.size() != 2 || acc.size() != 2 || done_c[1] != acc[1] + 5) begin
         bad++;
         $display("FAIL b2b second_done: done pulses=%0d, required 2 with second at accept+5", done_c.size());
      end
      exp_fc = (exp_fc + done_c.size()) % FC_MOD;
      @(negedge clk);
      total++;
      if (frame_count !== FCNT_W'(exp_fc)) begin
         bad++;
         $display("FAIL b2b frame_count: got %0d, required %0d", frame_count, exp_fc);
      end
   endtask

   task automatic test_reset_mid();
      bit got, saw_done, ready_bad;
      busy_polls = -1;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_back_addr = $urandom;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (pb_read) got = 1'b1;
      end
      total++;
      if (!got) begin
         bad++;
         $display("FAIL rst_mid reach_poll: no STATUS read seen, required one");
      end
      @(posedge clk); #1;       // now in POLL_WAIT
      rst = 1'b1;
      #1;
      exp_fc = 0;
      total++;
      if (pb_read !== 1'b0 || pb_write !== 1'b0 || busy !== 1'b0 ||
          frame_count !== '0 || done_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid immediate: rd=%0b wr=%0b busy=%0b fc=%0d done=%0b ready=%0b, required 0 0 0 0 0 1",
                  pb_read, pb_write, busy, frame_count, done_valid, req_ready);
      end
      busy_polls = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      ready_bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done_valid) saw_done = 1'b1;
         if (!req_ready) ready_bad = 1'b1;
      end
      total++;
      if (saw_done || ready_bad) begin
         bad++;
         $display("FAIL rst_mid after_release: done seen=%0b ready dropped=%0b, required 0 0", saw_done, ready_bad);
      end
   endtask

   task automatic test_timeout();
      bit got;
      int t_acc, done_rel;
      bit done_err;
      busy_polls = -1;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_back_addr = $urandom;
      got = 1'b0;
      t_acc = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1;
            t_acc = cyc;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
`ifdef VGA_SWAP_TIMEOUT_EN
      done_rel = -1;
      done_err = 1'b0;
      for (int i = 0; i < 300 && done_rel < 0; i++) begin
         @(negedge clk);
         if (done_valid) begin
            done_rel = cyc - t_acc;
            done_err = done_error;
         end
      end
      total++;
      if (done_rel < TIMEOUT_CYCLES || done_rel > TIMEOUT_CYCLES + PERIOD + 4 || done_err !== 1'b1) begin
         bad++;
         $display("FAIL timeout done: at +%0d error=%0b, required error=1 between +%0d and +%0d",
                  done_rel, done_err, TIMEOUT_CYCLES, TIMEOUT_CYCLES + PERIOD + 4);
      end
      @(negedge clk);
      total++;
      if (frame_count !== FCNT_W'(exp_fc) || busy !== 1'b0) begin
         bad++;
         $display("FAIL timeout frame_count: got %0d busy=%0b, required %0d 0", frame_count, busy, exp_fc);
      end
      busy_polls = 0;
`else
      done_rel = 0;
      done_err = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (done_valid) done_rel++;
         if (done_error) done_err = 1'b1;
      end
      total++;
      if (done_rel != 0 || done_err || busy !== 1'b1) begin
         bad++;
         $display("FAIL no_timeout: done pulses=%0d error=%0b busy=%0b, required 0 0 1", done_rel, done_err, busy);
      end
      rst = 1'b1;
      exp_fc = 0;
      busy_polls = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
`endif
   endtask

   task automatic test_wrap();
      int prev;
      for (int n = 0; n < FC_MOD + 1; n++) begin
         prev = exp_fc;
         run_swap($urandom, int'($urandom_range(0, 1)), "wrap");
         if (prev == FC_MOD - 1) begin
            total++;
            if (frame_count !== '0) begin
               bad++;
               $display("FAIL wrap to_zero: frame_count %0d after swap from %0d, required 0", frame_count, prev);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_swap();
      test_poll_busy();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
